// File: rtl/skew_buf_pkg.sv
// Shared constants and depth helpers for the skew_buf channel array.
// Channel c is delayed by BASE_DEPTH + c*STEP enabled cycles.
package skew_buf_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_BITS       = 8;
  localparam int DEF_BASE_DEPTH = 1;
  localparam int DEF_STEP       = 1;

  function automatic int depth_of(input int base_depth, input int step, input int c);
    return base_depth + c * step;
  endfunction

  function automatic int max_depth(input int channels, input int base_depth, input int step);
    return depth_of(base_depth, step, channels - 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One channel of the skew buffer: a DEPTH-stage shift register of data plus valid.
// Output is taken straight from the last stage flop.
module skew_delay_line
  import skew_buf_pkg::*;
#(
  parameter int DEPTH = DEF_BASE_DEPTH,
  parameter int BITS  = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [BITS-1:0] d,
  input  logic            d_valid,
  output logic [BITS-1:0] q,
  output logic            q_valid,
  output logic            any_valid
);

  logic [BITS-1:0]  data_q [DEPTH];
  logic [BITS-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // clr wins over en; data is captured on en regardless of d_valid
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) data_d[k] = '0;
      vld_d = '0;
    end else if (en) begin
      data_d[0] = d;
      vld_d[0]  = d_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q         = data_q[DEPTH-1];
  assign q_valid   = vld_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/skew_buf.sv
// Per-channel skewed delay buffer; channel c delays by BASE_DEPTH + c*STEP enabled cycles.
// Define SKEW_BUF_PRIME_EN to add the 'primed' output and its fill counter.
module skew_buf
  import skew_buf_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int BITS       = DEF_BITS,
  parameter int BASE_DEPTH = DEF_BASE_DEPTH,
  parameter int STEP       = DEF_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [CHANNELS*BITS-1:0] d,
  input  logic [CHANNELS-1:0]      d_valid,
  output logic [CHANNELS*BITS-1:0] q,
  output logic [CHANNELS-1:0]      q_valid,
  output logic                     busy
`ifdef SKEW_BUF_PRIME_EN
  ,
  output logic                     primed
`endif
);

  logic [CHANNELS-1:0] any_valid;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int DEPTH = depth_of(BASE_DEPTH, STEP, c);

    skew_delay_line #(
      .DEPTH(DEPTH),
      .BITS (BITS)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .d        (d[c*BITS +: BITS]),
      .d_valid  (d_valid[c]),
      .q        (q[c*BITS +: BITS]),
      .q_valid  (q_valid[c]),
      .any_valid(any_valid[c])
    );
  end

  assign busy = |any_valid;

`ifdef SKEW_BUF_PRIME_EN
  localparam int MAX_DEPTH = max_depth(CHANNELS, BASE_DEPTH, STEP);
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DEPTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts enabled cycles since reset/clr; once at the deepest channel's depth, every lane is full
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign primed = (cnt_q == CNT_MAX);
`endif

endmodule

// File: tb/tb_skew_buf.sv
// Randomised bench for skew_buf against a queue-based history model, plus directed scenarios.
// Define SKEW_BUF_PRIME_EN to also exercise the primed output.
module tb_skew_buf;

  localparam int CH   = 4;
  localparam int BITS = 8;
  localparam int BASE = 1;
  localparam int STEP = 1;
  localparam int MAXD = BASE + (CH - 1) * STEP;
  localparam logic [31:0] PAT = 32'h4433_2211;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 clr = 1'b0;
  logic [CH*BITS-1:0]   d = '0;
  logic [CH-1:0]        d_valid = '0;
  logic [CH*BITS-1:0]   q;
  logic [CH-1:0]        q_valid;
  logic                 busy;
`ifdef SKEW_BUF_PRIME_EN
  logic                 primed;
`endif

  skew_buf #(
    .CHANNELS  (CH),
    .BITS      (BITS),
    .BASE_DEPTH(BASE),
    .STEP      (STEP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .d      (d),
    .d_valid(d_valid),
    .q      (q),
    .q_valid(q_valid),
    .busy   (busy)
`ifdef SKEW_BUF_PRIME_EN
    ,
    .primed (primed)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of accepted words since last reset/clr, newest first
  typedef struct {
    logic [CH*BITS-1:0] data;
    logic [CH-1:0]      vld;
  } entry_t;

  entry_t hist[$];
  int     en_count = 0;

  function automatic int dep(input int c);
    return BASE + c * STEP;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        hist.delete();
        en_count = 0;
      end else if (en) begin
        hist.push_front('{data: d, vld: d_valid});
        if (hist.size() > MAXD) void'(hist.pop_back());
        if (en_count < MAXD) en_count++;
      end
    end
  end

  always @(negedge rst_n) begin
    hist.delete();
    en_count = 0;
  end

  function automatic logic [CH*BITS-1:0] exp_q();
    logic [CH*BITS-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      if (hist.size() >= dep(c)) r[c*BITS +: BITS] = hist[dep(c)-1].data[c*BITS +: BITS];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_qv();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      if (hist.size() >= dep(c)) r[c] = hist[dep(c)-1].vld[c];
    return r;
  endfunction

  function automatic logic exp_busy();
    logic r = 1'b0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < dep(c) && k < hist.size(); k++)
        if (hist[k].vld[c]) r = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q", 32'(q), 32'(exp_q()));
      check("model_q_valid", 32'(q_valid), 32'(exp_qv()));
      check("model_busy", 32'(busy), 32'(exp_busy()));
`ifdef SKEW_BUF_PRIME_EN
      check("model_primed", 32'(primed), 32'(en_count == MAXD));
`endif
    end
  end

  task automatic cyc(input logic e, input logic c, input logic [31:0] dd, input logic [3:0] dv);
    en = e;
    clr = c;
    d = dd;
    d_valid = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_q_valid", 32'(q_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Skew: one valid word fans out at cycles 1..4
    cyc(1'b1, 1'b0, PAT, 4'hF);
    check("skew_qv_1", 32'(q_valid), 32'h1);
    check("skew_q_1", 32'(q[7:0]), 32'h11);
    for (int k = 1; k < CH; k++) begin
      cyc(1'b1, 1'b0, $urandom, 4'h0);
      check("skew_qv", 32'(q_valid), 32'(1 << k));
      check("skew_q", 32'(q[k*BITS +: BITS]), 32'(8'h11 * (k + 1)));
    end
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("skew_qv_done", 32'(q_valid), 32'h0);
    check("skew_busy_done", 32'(busy), 32'h0);

    // Stall: outputs freeze while en=0
    cyc(1'b0, 1'b1, 32'h0, 4'h0);
    cyc(1'b1, 1'b0, PAT, 4'hF);
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("stall_qv_2", 32'(q_valid), 32'h2);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, $urandom, 4'($urandom));
      check("stall_frozen_qv", 32'(q_valid), 32'h2);
      check("stall_frozen_q", 32'(q[15:8]), 32'h22);
    end
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("stall_qv_6", 32'(q_valid), 32'h4);
    check("stall_q_6", 32'(q[23:16]), 32'h33);
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("stall_qv_7", 32'(q_valid), 32'h8);
    check("stall_q_7", 32'(q[31:24]), 32'h44);

    // clr beats en and discards d
    cyc(1'b0, 1'b1, 32'h0, 4'h0);
    cyc(1'b1, 1'b0, PAT, 4'hF);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF);
    check("clr_q", 32'(q), 32'h0);
    check("clr_qv", 32'(q_valid), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);

    // busy spans exactly the 4 cycles channel 3 holds its entry
    cyc(1'b1, 1'b0, $urandom, 4'h8);
    check("busy_1", 32'(busy), 32'h1);
    for (int k = 2; k <= 4; k++) begin
      cyc(1'b1, 1'b0, $urandom, 4'h0);
      check("busy_n", 32'(busy), 32'h1);
    end
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("busy_5", 32'(busy), 32'h0);

    // Async reset between edges with the lanes full
    cyc(1'b1, 1'b0, $urandom, 4'hF);
    cyc(1'b1, 1'b0, $urandom, 4'hF);
    cyc(1'b1, 1'b0, $urandom, 4'hF);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_qv", 32'(q_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    #2 rst_n = 1'b1;
    cyc(1'b1, 1'b0, PAT, 4'hF);
    check("post_rst_qv", 32'(q_valid), 32'h1);

`ifdef SKEW_BUF_PRIME_EN
    cyc(1'b0, 1'b1, 32'h0, 4'h0);
    check("prime_clr", 32'(primed), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, $urandom, 4'($urandom));
      check("prime_ramp", 32'(primed), 32'(k == 4));
    end
    cyc(1'b0, 1'b0, $urandom, 4'h0);
    check("prime_hold", 32'(primed), 32'h1);
    cyc(1'b1, 1'b0, $urandom, 4'h0);
    check("prime_sat", 32'(primed), 32'h1);
    cyc(1'b0, 1'b1, $urandom, 4'h0);
    check("prime_drop", 32'(primed), 32'h0);
`endif

    // Random traffic with occasional clr and async reset
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 39) == 0),
          $urandom, 4'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_buf.md
SKEW_BUF -- requirements
Module: skew_buf

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent delay channels (>=1).
REQ-002 SHALL have parameter BITS, default 8, data width per channel (>=1).
REQ-003 SHALL have parameter BASE_DEPTH, default 1, delay of channel 0 in enabled cycles (>=1).
REQ-004 SHALL have parameter STEP, default 1, extra delay per channel index (>=0; 0 gives uniform delay).
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  shift enable, all channels advance together.
REQ-008 SHALL have port clr  input  1  synchronous clear of all stages.
REQ-009 SHALL have port d  input  CHANNELS*BITS  input word, channel c at bits [c*BITS +: BITS].
REQ-010 SHALL have port d_valid  input  CHANNELS  per-channel input valid qualifier.
REQ-011 SHALL have port q  output  CHANNELS*BITS  oldest stage of each channel, same packing as d.
REQ-012 SHALL have port q_valid  output  CHANNELS  valid bit of the oldest stage of each channel.
REQ-013 SHALL have port busy  output  1  high when any stage of any channel holds a valid bit.

Function
REQ-014 SHALL give channel c depth D(c) = BASE_DEPTH + c*STEP; MAX_DEPTH = D(CHANNELS-1).
REQ-015 SHALL, on a cycle with en=1 and clr=0, shift each channel one stage: stage 0 <= {d_c, d_valid[c]}, stage k <= stage k-1.
REQ-016 SHALL hold all stages unchanged when en=0 and clr=0.
REQ-017 SHALL drive q/q_valid of channel c from its last stage, registered; a word accepted at enabled cycle N appears at q after exactly D(c) enabled cycles.
REQ-018 SHALL store d unconditionally when en=1 regardless of d_valid; d_valid only marks the entry.
REQ-019 SHALL, on clr=1, zero all data and valid bits at the next edge; clr has priority over en, and d is discarded that cycle.
REQ-020 SHALL compute busy combinationally as the OR of every valid bit in every stage of every channel.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force all data stages, valid bits, q, q_valid and busy to 0.
REQ-022 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-stream loses all in-flight entries.

Configuration
REQ-023 SHALL compile a priming counter when macro SKEW_BUF_PRIME_EN is defined: extra output primed (1 bit), high once MAX_DEPTH enabled cycles have elapsed since the last reset or clr.
REQ-024 SHALL implement the counter as width $clog2(MAX_DEPTH+1), incrementing on en=1, clr=0, saturating at MAX_DEPTH, zeroed by reset and clr.
REQ-025 SHALL, without SKEW_BUF_PRIME_EN, omit the primed port and counter entirely; all other behaviour unchanged.

Structure
REQ-026 SHALL place depth function D(c), MAX_DEPTH helper and default parameter constants in package skew_buf_pkg.
REQ-027 SHALL instantiate one sub-module skew_delay_line per channel (parameters DEPTH, BITS; ports clk, rst_n, en, clr, d, d_valid, q, q_valid, any_valid) via generate loop.

Verification (CHANNELS=4, BITS=8, BASE_DEPTH=1, STEP=1: depths 1,2,3,4)
REQ-028 SHALL check skew: en=1 constantly, d={8'h44,8'h33,8'h22,8'h11}, d_valid=4'hF for one cycle then 0 -> q_valid[0..3] each high once, at enabled cycles 1,2,3,4 with q bytes 11,22,33,44.
REQ-029 SHALL check stall: same stimulus with en=0 for 3 cycles after cycle 2 -> outputs frozen during stall, channel 3 emits 44 at total cycle 7.
REQ-030 SHALL check clr priority: load 4'hF valid, at cycle 2 assert clr with en=1 and d=8'hFF -> next cycle all q=0, q_valid=0, busy=0.
REQ-031 SHALL check busy: single valid on channel 3 only -> busy high for exactly 4 enabled cycles, low after.
REQ-032 SHALL check async reset mid-stream: rst_n low between edges while channels full -> q, q_valid, busy 0 immediately without clock.
REQ-033 SHALL check, with SKEW_BUF_PRIME_EN, primed rises after 4th enabled cycle, stays high, and drops to 0 on clr.
